// File: rtl/driver_rgb_pwm_pkg.sv
// Shared constants for the RGB PWM driver: colour patterns, RGB bit positions
// and the one-hot colour codes accepted on the load interface.
package driver_rgb_pwm_pkg;

  // Colour patterns, bit order {B, R, G}
  localparam logic [2:0] COR_OFF = 3'b000;
  localparam logic [2:0] COR_R   = 3'b010;
  localparam logic [2:0] COR_G   = 3'b001;
  localparam logic [2:0] COR_B   = 3'b100;
  localparam logic [2:0] COR_RG  = 3'b011;

  localparam int BIT_G = 0;
  localparam int BIT_R = 1;
  localparam int BIT_B = 2;

  localparam logic [3:0] CODIGO_R  = 4'b0001;
  localparam logic [3:0] CODIGO_B  = 4'b0010;
  localparam logic [3:0] CODIGO_RG = 4'b0100;
  localparam logic [3:0] CODIGO_G  = 4'b1000;

endpackage

// File: rtl/driver_rgb_pwm_decodificador_cor.sv
// Combinational one-hot colour decoder; any non-legal code decodes to off.
module decodificador_cor
  import driver_rgb_pwm_pkg::*;
(
  input  logic [3:0] codigo,
  output logic [2:0] cor
);

  // one-hot code to colour lookup
  always_comb begin
    cor = COR_OFF;
    case (codigo)
      CODIGO_R:  cor = COR_R;
      CODIGO_B:  cor = COR_B;
      CODIGO_RG: cor = COR_RG;
      CODIGO_G:  cor = COR_G;
      default:   cor = COR_OFF;
    endcase
  end

endmodule

// File: rtl/driver_rgb_pwm.sv
// Multi-channel RGB LED driver with per-channel brightness PWM and optional
// blink gating (blink logic present only when DRIVER_RGB_PISCA_EN is defined).
module driver_rgb_pwm
  import driver_rgb_pwm_pkg::*;
#(
  parameter int N_CANAIS    = 2,
  parameter int LARGURA_PWM = 4,
  parameter int DIV_PISCA   = 16,
  localparam int LARGURA_CANAL = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
)(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     carrega,
  input  logic [LARGURA_CANAL-1:0] canal,
  input  logic [3:0]               dados,
  input  logic [LARGURA_PWM-1:0]   brilho,
  input  logic                     pisca,
  output logic [3*N_CANAIS-1:0]    leds_rgb,
  output logic                     erro
);

  logic [2:0]              cor_s;
  logic [31:0]             canal_ext_s;
  logic                    canal_ok_s;
  logic                    wrap_s;
  logic [LARGURA_PWM-1:0]  cnt_pwm_r;
  logic [2:0]              cor_r    [N_CANAIS];
  logic [LARGURA_PWM-1:0]  brilho_r [N_CANAIS];
  logic [N_CANAIS-1:0]     pisca_ok_s;
  logic [N_CANAIS-1:0]     on_s;
  logic [3*N_CANAIS-1:0]   leds_s;
  logic [3*N_CANAIS-1:0]   leds_r;
  logic                    erro_r;

  decodificador_cor u_decodificador_cor (
    .codigo (dados),
    .cor    (cor_s)
  );

  assign canal_ext_s = 32'(canal);
  assign canal_ok_s  = (canal_ext_s < 32'(N_CANAIS));
  assign wrap_s      = (cnt_pwm_r == {LARGURA_PWM{1'b1}});

  // free-running PWM counter, never disturbed by loads
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_pwm_r <= {LARGURA_PWM{1'b0}};
    end else begin
      cnt_pwm_r <= cnt_pwm_r + {{(LARGURA_PWM-1){1'b0}}, 1'b1};
    end
  end

  // per-channel colour and brightness storage, written only for a valid index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N_CANAIS; c++) begin
        cor_r[c]    <= COR_OFF;
        brilho_r[c] <= {LARGURA_PWM{1'b0}};
      end
    end else begin
      for (int c = 0; c < N_CANAIS; c++) begin
        if (carrega && (canal_ext_s == 32'(c))) begin
          cor_r[c]    <= cor_s;
          brilho_r[c] <= brilho;
        end
      end
    end
  end

`ifdef DRIVER_RGB_PISCA_EN
  localparam int LARGURA_DIV = $clog2(DIV_PISCA) + 1;

  logic [LARGURA_DIV-1:0] cnt_pisca_r;
  logic                   fase_pisca_r;
  logic [N_CANAIS-1:0]    pisca_r;

  // blink period counter: advances once per PWM wrap, toggles phase every DIV_PISCA wraps
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_pisca_r  <= {LARGURA_DIV{1'b0}};
      fase_pisca_r <= 1'b0;
    end else if (wrap_s) begin
      if (cnt_pisca_r == LARGURA_DIV'(DIV_PISCA - 1)) begin
        cnt_pisca_r  <= {LARGURA_DIV{1'b0}};
        fase_pisca_r <= ~fase_pisca_r;
      end else begin
        cnt_pisca_r  <= cnt_pisca_r + {{(LARGURA_DIV-1){1'b0}}, 1'b1};
      end
    end
  end

  // per-channel blink request storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pisca_r <= {N_CANAIS{1'b0}};
    end else begin
      for (int c = 0; c < N_CANAIS; c++) begin
        if (carrega && (canal_ext_s == 32'(c))) begin
          pisca_r[c] <= pisca;
        end
      end
    end
  end

  // blinking channels are held dark during phase 0
  always_comb begin
    pisca_ok_s = {N_CANAIS{1'b0}};
    for (int c = 0; c < N_CANAIS; c++) begin
      pisca_ok_s[c] = ~pisca_r[c] | fase_pisca_r;
    end
  end
`else
  logic unused_pisca_s;

  assign unused_pisca_s = pisca;
  assign pisca_ok_s     = {N_CANAIS{1'b1}};
`endif

  // LED drive from pre-edge state: full-scale brightness is always on, zero never
  always_comb begin
    on_s   = {N_CANAIS{1'b0}};
    leds_s = {3*N_CANAIS{1'b0}};
    for (int c = 0; c < N_CANAIS; c++) begin
      on_s[c] = (brilho_r[c] == {LARGURA_PWM{1'b1}}) || (cnt_pwm_r < brilho_r[c]);
      leds_s[3*c +: 3] = cor_r[c] & {3{on_s[c] & pisca_ok_s[c]}};
    end
  end

  // output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      leds_r <= {3*N_CANAIS{1'b0}};
      erro_r <= 1'b0;
    end else begin
      leds_r <= leds_s;
      erro_r <= carrega & ~canal_ok_s;
    end
  end

  assign leds_rgb = leds_r;
  assign erro     = erro_r;

endmodule

// File: tb/tb_driver_rgb_pwm.sv
// Directed, table-driven bench for driver_rgb_pwm (3 channels so index 3 is out of range).
module tb_driver_rgb_pwm;

  localparam int N  = 3;
  localparam int W  = 4;
  localparam int DV = 2;

  logic         clock;
  logic         reset;
  logic         carrega;
  logic [1:0]   canal;
  logic [3:0]   dados;
  logic [W-1:0] brilho;
  logic         pisca;
  logic [3*N-1:0] leds_rgb;
  logic         erro;

  int total;
  int bad;

  driver_rgb_pwm #(.N_CANAIS(N), .LARGURA_PWM(W), .DIV_PISCA(DV)) dut (
    .clock    (clock),
    .reset    (reset),
    .carrega  (carrega),
    .canal    (canal),
    .dados    (dados),
    .brilho   (brilho),
    .pisca    (pisca),
    .leds_rgb (leds_rgb),
    .erro     (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] dados;
    logic [2:0] cor;
  } dec_vec_t;

  typedef struct {
    logic [W-1:0] brilho;
    int           alto;
  } pwm_vec_t;

  dec_vec_t dec_tab [16];
  pwm_vec_t pwm_tab [5];

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nome, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [1:0] c, input logic [3:0] d, input logic [W-1:0] b, input logic p);
    carrega = 1'b1;
    canal   = c;
    dados   = d;
    brilho  = b;
    pisca   = p;
    tick();
    carrega = 1'b0;
  endtask

  initial begin
    int n;
    logic lvl;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    carrega = 1'b0;
    canal = 2'd0;
    dados = 4'd0;
    brilho = 4'd0;
    pisca = 1'b0;

    for (int i = 0; i < 16; i++) begin
      dec_tab[i].dados = 4'(i);
      dec_tab[i].cor   = 3'b000;
    end
    dec_tab[1].cor = 3'b010;
    dec_tab[2].cor = 3'b100;
    dec_tab[4].cor = 3'b011;
    dec_tab[8].cor = 3'b001;

    pwm_tab[0] = '{4'b0000, 0};
    pwm_tab[1] = '{4'b0001, 1};
    pwm_tab[2] = '{4'b0101, 5};
    pwm_tab[3] = '{4'b1110, 14};
    pwm_tab[4] = '{4'b1111, 16};

    #2;
    check("reset_leds", 32'(leds_rgb), 32'h0);
    check("reset_erro", 32'(erro), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();

    // colour decode sweep on channel 0 at full brightness
    for (int i = 0; i < 16; i++) begin
      load(2'd0, dec_tab[i].dados, 4'hF, 1'b0);
      tick();
      check($sformatf("decode_%0d", i), 32'(leds_rgb[2:0]), 32'(dec_tab[i].cor));
    end

    // PWM duty over one full 16-cycle period
    for (int i = 0; i < 5; i++) begin
      load(2'd0, 4'b0001, pwm_tab[i].brilho, 1'b0);
      tick();
      n = 0;
      for (int k = 0; k < 16; k++) begin
        if (leds_rgb[1]) n++;
        tick();
      end
      check($sformatf("pwm_b%0d", pwm_tab[i].brilho), 32'(n), 32'(pwm_tab[i].alto));
    end

    // independence and two-edge latency
    load(2'd0, 4'b0100, 4'hF, 1'b0);
    load(2'd1, 4'b0001, 4'hF, 1'b0);
    tick();
    check("indep_pre", 32'(leds_rgb), 32'b000_010_011);
    load(2'd1, 4'b1000, 4'hF, 1'b0);
    check("indep_edge1", 32'(leds_rgb), 32'b000_010_011);
    tick();
    check("indep_edge2", 32'(leds_rgb), 32'b000_001_011);

    // back-to-back loads keep only the latest
    load(2'd1, 4'b0010, 4'h3, 1'b0);
    load(2'd1, 4'b1000, 4'hF, 1'b0);
    tick();
    check("b2b_latest", 32'(leds_rgb), 32'b000_001_011);

    // out-of-range index
    check("bad_pre_erro", 32'(erro), 32'h0);
    load(2'd3, 4'b0010, 4'hF, 1'b0);
    check("bad_erro_hi", 32'(erro), 32'h1);
    tick();
    check("bad_erro_lo", 32'(erro), 32'h0);
    check("bad_leds", 32'(leds_rgb), 32'b000_001_011);

`ifdef DRIVER_RGB_PISCA_EN
    // blink: 32 cycles per phase with DIV_PISCA=2
    load(2'd2, 4'b0001, 4'hF, 1'b1);
    tick();
    lvl = leds_rgb[7];
    n = 0;
    while (leds_rgb[7] == lvl && n < 80) begin
      tick();
      n++;
    end
    check("blink_found_edge", 32'(n < 80), 32'h1);
    for (int k = 0; k < 2; k++) begin
      lvl = leds_rgb[7];
      n = 0;
      while (leds_rgb[7] == lvl && n < 80) begin
        tick();
        n++;
      end
      check($sformatf("blink_run_%0d", k), 32'(n), 32'd32);
    end
    check("blink_ch01", 32'(leds_rgb[5:0]), 32'b001_011);
`else
    // blink request is ignored: channel stays on
    load(2'd2, 4'b0001, 4'hF, 1'b1);
    tick();
    n = 0;
    for (int k = 0; k < 64; k++) begin
      if (leds_rgb[7]) n++;
      tick();
    end
    check("nopisca_on", 32'(n), 32'd64);
`endif

    // asynchronous reset mid-period with a bad load in progress
    load(2'd0, 4'b0100, 4'h7, 1'b0);
    load(2'd1, 4'b1000, 4'h9, 1'b0);
    tick();
    tick();
    tick();
    carrega = 1'b1;
    canal   = 2'd3;
    tick();
    check("rst_pre_erro", 32'(erro), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_leds", 32'(leds_rgb), 32'h0);
    check("rst_async_erro", 32'(erro), 32'h0);
    carrega = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (leds_rgb != 9'd0) n++;
    end
    check("rst_stay_off", 32'(n), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
